// File: rtl/clock_pkg.sv
// Shared encodings and limits for the time-set keypad.
// Wrap helper keeps every edited field inside its legal range.
package clock_pkg;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_EDIT_HOUR,
      ST_EDIT_MIN,
      ST_EDIT_SEC,
      ST_COMMIT
   } state_t;

   typedef enum logic [1:0] {
      FIELD_NONE = 2'd0,
      FIELD_HOUR = 2'd1,
      FIELD_MIN  = 2'd2,
      FIELD_SEC  = 2'd3
   } field_t;

   localparam logic [5:0] MAX_HOUR   = 6'd23;
   localparam logic [5:0] MAX_MINSEC = 6'd59;

   localparam int KEY_MODE = 0;
   localparam int KEY_UP   = 1;
   localparam int KEY_DOWN = 2;

   function automatic logic [5:0] wrap_adj(
      input logic [5:0] v,
      input logic [5:0] max,
      input logic       up,
      input logic       dn
   );
      if (up) return (v >= max) ? 6'd0 : v + 6'd1;
      if (dn) return (v == 6'd0) ? max : v - 6'd1;
      return v;
   endfunction

endpackage

// File: rtl/time_set_keypad_if.sv
// Bus between the keypad and the time counter:
// live time flows in, committed time and load strobe flow out.
interface time_set_keypad_if;

   logic       load;
   logic [4:0] load_hour;
   logic [5:0] load_min;
   logic [5:0] load_sec;
   logic [4:0] cur_hour;
   logic [5:0] cur_min;
   logic [5:0] cur_sec;

   modport master (
      output load, load_hour, load_min, load_sec,
      input  cur_hour, cur_min, cur_sec
   );

   modport slave (
      input  load, load_hour, load_min, load_sec,
      output cur_hour, cur_min, cur_sec
   );

endinterface

// File: rtl/key_debounce.sv
// One key: 2-FF sync, counter debounce, press edge and
// auto-repeat step (first after REPEAT_DELAY, then every REPEAT_RATE).
module key_debounce #(
   parameter int DEB_CYCLES   = 1000,
   parameter int REPEAT_DELAY = 20000,
   parameter int REPEAT_RATE  = 5000,
   parameter int CNT_W        = 20
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press,
   output logic step
);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] RPT_DLY  = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] RPT_RATE = CNT_W'(REPEAT_RATE);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   logic             s0, s1, level_d, rep, fire;
   logic [CNT_W-1:0] deb_cnt, rpt_cnt;

   assign fire  = level &&
                  (rep ? rpt_cnt == RPT_RATE : rpt_cnt == RPT_DLY);
   assign press = level & ~level_d;
   assign step  = press | fire;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s0      <= 1'b0;
         s1      <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         rep     <= 1'b0;
         deb_cnt <= '0;
         rpt_cnt <= '0;
      end else begin
         s0      <= raw;
         s1      <= s0;
         level_d <= level;
         if (s1 == level) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            deb_cnt <= '0;
            level   <= s1;
         end else begin
            deb_cnt <= deb_cnt + ONE;
         end
         // rpt_cnt counts cycles since the last step while held
         if (!level) begin
            rpt_cnt <= '0;
            rep     <= 1'b0;
         end else if (fire) begin
            rpt_cnt <= ONE;
            rep     <= 1'b1;
         end else begin
            rpt_cnt <= rpt_cnt + ONE;
         end
      end
   end

endmodule

// File: rtl/time_set_keypad.sv
// Time-set front end: three debounced keys drive an edit FSM
// that adjusts hour/min/sec and commits them with a load strobe.
module time_set_keypad
   import clock_pkg::*;
#(
   parameter int DEB_CYCLES   = 1000,
   parameter int REPEAT_DELAY = 20000,
   parameter int REPEAT_RATE  = 5000,
   parameter int EDIT_TIMEOUT = 500000,
   parameter int CNT_W        = 20
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [2:0]                 key_raw,
   output logic                       edit_active,
   output logic [1:0]                 edit_field,
   output logic [2:0]                 blink_mask,
   time_set_keypad_if.master          tbus
);

   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(EDIT_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   logic [2:0] lvl_unused, press, step;
   logic       mode_rpt_unused;

   for (genvar i = 0; i < 3; i++) begin : g_key
      key_debounce #(
         .DEB_CYCLES  (DEB_CYCLES),
         .REPEAT_DELAY(REPEAT_DELAY),
         .REPEAT_RATE (REPEAT_RATE),
         .CNT_W       (CNT_W)
      ) u_key (
         .clock(clock),
         .reset(reset),
         .raw  (key_raw[i]),
         .level(lvl_unused[i]),
         .press(press[i]),
         .step (step[i])
      );
   end

   assign mode_rpt_unused = step[KEY_MODE];

   state_t           state, state_n;
   field_t           field_n;
   logic [2:0]       mask_n;
   logic [4:0]       ed_hour;
   logic [5:0]       ed_min, ed_sec;
   logic [CNT_W-1:0] idle_cnt;
   logic             mode_p, any_p, up_ev, dn_ev, in_edit, timeout;

   // MODE outranks steps; opposing steps cancel
   assign mode_p  = press[KEY_MODE];
   assign any_p   = |press;
   assign up_ev   = step[KEY_UP] & ~step[KEY_DOWN] & ~mode_p;
   assign dn_ev   = step[KEY_DOWN] & ~step[KEY_UP] & ~mode_p;
   assign in_edit = state inside {ST_EDIT_HOUR, ST_EDIT_MIN, ST_EDIT_SEC};
   assign timeout = in_edit && !any_p && idle_cnt == IDLE_LAST;

   always_comb begin
      state_n = state;
      unique case (state)
         ST_RUN:       if (mode_p) state_n = ST_EDIT_HOUR;
         ST_EDIT_HOUR: if (mode_p) state_n = ST_EDIT_MIN;
                       else if (timeout) state_n = ST_RUN;
         ST_EDIT_MIN:  if (mode_p) state_n = ST_EDIT_SEC;
                       else if (timeout) state_n = ST_RUN;
         ST_EDIT_SEC:  if (mode_p) state_n = ST_COMMIT;
                       else if (timeout) state_n = ST_RUN;
         ST_COMMIT:    state_n = ST_RUN;
         default:      state_n = ST_RUN;
      endcase
   end

   always_comb begin
      field_n = FIELD_NONE;
      mask_n  = 3'b000;
      unique case (state_n)
         ST_EDIT_HOUR: begin field_n = FIELD_HOUR; mask_n = 3'b100; end
         ST_EDIT_MIN:  begin field_n = FIELD_MIN;  mask_n = 3'b010; end
         ST_EDIT_SEC:  begin field_n = FIELD_SEC;  mask_n = 3'b001; end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= ST_RUN;
         edit_active    <= 1'b0;
         edit_field     <= 2'd0;
         blink_mask     <= 3'b000;
         ed_hour        <= '0;
         ed_min         <= '0;
         ed_sec         <= '0;
         idle_cnt       <= '0;
         tbus.load      <= 1'b0;
         tbus.load_hour <= '0;
         tbus.load_min  <= '0;
         tbus.load_sec  <= '0;
      end else begin
         state       <= state_n;
         edit_active <= field_n != FIELD_NONE;
         edit_field  <= field_n;
         blink_mask  <= mask_n;
         tbus.load   <= state_n == ST_COMMIT;
         if (state_n == ST_COMMIT) begin
            tbus.load_hour <= ed_hour;
            tbus.load_min  <= ed_min;
            tbus.load_sec  <= ed_sec;
         end
         if (!in_edit || any_p) idle_cnt <= '0;
         else                   idle_cnt <= idle_cnt + ONE;
         if (state == ST_RUN && mode_p) begin
            ed_hour <= tbus.cur_hour;
            ed_min  <= tbus.cur_min;
            ed_sec  <= tbus.cur_sec;
         end else if (state_n == state) begin
            unique case (1'b1)
               state == ST_EDIT_HOUR: ed_hour <= 5'(wrap_adj(
                  {1'b0, ed_hour}, MAX_HOUR, up_ev, dn_ev));
               state == ST_EDIT_MIN:  ed_min <= wrap_adj(
                  ed_min, MAX_MINSEC, up_ev, dn_ev);
               state == ST_EDIT_SEC:  ed_sec <= wrap_adj(
                  ed_sec, MAX_MINSEC, up_ev, dn_ev);
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_time_set_keypad.sv
// Directed bench: stimulus pushes expected commits into a queue,
// a monitor pops and compares on every load strobe.
module tb_time_set_keypad;

   typedef struct packed {
      logic [4:0] h;
      logic [5:0] m;
      logic [5:0] s;
   } tm_t;

   localparam logic [2:0] K_M  = 3'b001;
   localparam logic [2:0] K_U  = 3'b010;
   localparam logic [2:0] K_D  = 3'b100;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] key_raw = 3'b000;
   logic       edit_active;
   logic [1:0] edit_field;
   logic [2:0] blink_mask;

   time_set_keypad_if tbus();

   always #5 clock = ~clock;

   time_set_keypad #(
      .DEB_CYCLES  (4),
      .REPEAT_DELAY(20),
      .REPEAT_RATE (5),
      .EDIT_TIMEOUT(200),
      .CNT_W       (20)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .key_raw    (key_raw),
      .edit_active(edit_active),
      .edit_field (edit_field),
      .blink_mask (blink_mask),
      .tbus       (tbus)
   );

   int   checks = 0;
   int   errors = 0;
   tm_t  exp_q[$];
   tm_t  e;
   logic load_d = 1'b0;

   always @(negedge clock) begin
      if (reset) begin
         if (tbus.load) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_load got %0d:%0d:%0d expected no load",
                        tbus.load_hour, tbus.load_min, tbus.load_sec);
            end else begin
               e = exp_q.pop_front();
               if (tbus.load_hour != e.h || tbus.load_min != e.m ||
                   tbus.load_sec != e.s) begin
                  errors++;
                  $display("FAIL load_value got %0d:%0d:%0d expected %0d:%0d:%0d",
                           tbus.load_hour, tbus.load_min, tbus.load_sec,
                           e.h, e.m, e.s);
               end
            end
            if (load_d) begin
               errors++;
               $display("FAIL load_width got 2+ cycles expected 1");
            end
         end
         load_d = tbus.load;
      end else begin
         load_d = 1'b0;
      end
   end

   task automatic chk(input string nm, input int got, input int expv);
      checks++;
      if (got != expv) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, got, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic tap(input logic [2:0] k);
      key_raw = k;
      tick(10);
      key_raw = 3'b000;
      tick(12);
   endtask

   task automatic set_cur(input int h, input int m, input int s);
      tbus.cur_hour = 5'(h);
      tbus.cur_min  = 6'(m);
      tbus.cur_sec  = 6'(s);
   endtask

   task automatic push(input int h, input int m, input int s);
      exp_q.push_back('{h: 5'(h), m: 6'(m), s: 6'(s)});
   endtask

   task automatic chk_state(input string nm, input int f);
      int mask;
      mask = (f == 0) ? 0 : (4 >> (f - 1));
      chk({nm, "_active"}, int'(edit_active), int'(f != 0));
      chk({nm, "_field"}, int'(edit_field), f);
      chk({nm, "_mask"}, int'(blink_mask), mask);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_active"}, int'(edit_active), 0);
      chk({nm, "_field"}, int'(edit_field), 0);
      chk({nm, "_mask"}, int'(blink_mask), 0);
      chk({nm, "_load"}, int'(tbus.load), 0);
      chk({nm, "_lhour"}, int'(tbus.load_hour), 0);
      chk({nm, "_lmin"}, int'(tbus.load_min), 0);
      chk({nm, "_lsec"}, int'(tbus.load_sec), 0);
   endtask

   initial begin
      set_cur(0, 0, 0);
      tick(3);
      chk_zero("reset");
      reset = 1'b1;
      tick(2);

      // glitch then clean MODE press
      set_cur(12, 34, 56);
      key_raw = K_M;
      tick(3);
      key_raw = 3'b000;
      tick(12);
      chk_state("glitch", 0);
      tap(K_M);
      chk_state("edit_hour", 1);
      tap(K_M);
      chk_state("edit_min", 2);
      tap(K_M);
      chk_state("edit_sec", 3);
      push(12, 34, 56);
      tap(K_M);
      chk_state("after_commit", 0);

      // wrap: hour 23 up, min 0 down
      set_cur(23, 0, 0);
      tap(K_M);
      tap(K_U);
      tap(K_M);
      tap(K_D);
      tap(K_M);
      push(0, 59, 0);
      tap(K_M);
      // wrap: hour 0 down
      set_cur(0, 0, 0);
      tap(K_M);
      tap(K_D);
      tap(K_M);
      tap(K_M);
      push(23, 0, 0);
      tap(K_M);

      // full edit sequence
      set_cur(12, 34, 56);
      tap(K_M);
      tap(K_U);
      tap(K_U);
      tap(K_M);
      tap(K_M);
      tap(K_D);
      push(14, 34, 55);
      tap(K_M);
      chk_state("full_done", 0);

      // auto-repeat: 43 raw cycles keeps the level up 43 cycles
      set_cur(0, 0, 10);
      tap(K_M);
      tap(K_M);
      tap(K_M);
      chk_state("rpt_sec", 3);
      key_raw = K_U;
      tick(43);
      key_raw = 3'b000;
      tick(12);
      push(0, 0, 16);
      tap(K_M);

      // simultaneous events
      set_cur(5, 6, 7);
      tap(K_M);
      tap(K_U | K_D);
      chk_state("updn", 1);
      tap(K_M | K_U);
      chk_state("mode_up", 2);
      tap(K_M);
      push(5, 6, 7);
      tap(K_M);

      // timeout in EDIT_MIN
      set_cur(1, 2, 3);
      tap(K_M);
      tap(K_M);
      chk_state("to_min", 2);
      tick(150);
      chk_state("to_early", 2);
      tick(100);
      chk_state("to_done", 0);
      chk("to_lhour", int'(tbus.load_hour), 5);
      chk("to_lmin", int'(tbus.load_min), 6);
      chk("to_lsec", int'(tbus.load_sec), 7);

      // reset mid-edit
      set_cur(9, 9, 9);
      tap(K_M);
      tap(K_M);
      tap(K_M);
      chk_state("pre_rst", 3);
      reset = 1'b0;
      #1;
      chk_zero("mid_rst");
      tick(2);
      reset = 1'b1;
      tick(2);
      chk_state("post_rst", 0);

      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
